// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and monitor state encoding, shared by the
// receive monitor and the sync generator.
package vga_timing_pkg;

    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] H_TIMEOUT    = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Polarity-corrected leading-edge detector for one sampled sync pin.
module vga_sync_edge #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_raw,
    output logic rise
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic prev_raw;

    // Resets to the same raw value as the cleared sample register, so
    // releasing reset never fabricates an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_raw <= 1'b0;
        else       prev_raw <= sync_raw;
    end

    assign rise = (sync_raw ^ POL) & ~(prev_raw ^ POL);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel position from sampled syncs, checks
// line/frame timing, locks after consecutive good frames, checksums frames.
module vga_rx_monitor
    import vga_timing_pkg::*;
#(
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_active,
    output logic [5:0]  rgb_out,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  err_count
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    logic [7:0]  samp;
    logic        hs_edge, vs_edge;
    vga_state_e  state, state_nxt;
    logic [9:0]  hcnt, vcnt, v_lines;
    logic [9:0]  x_q, y_q, x_nxt, y_nxt;
    logic        first_hs, frame_bad;
    logic [7:0]  good_cnt;
    logic [15:0] run_sum;
    logic        tracking, line_err, tmo_err, vframe_err, err, frame_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) samp <= 8'd0;
        else       samp <= vga_in;
    end

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk(clk), .reset(reset), .sync_raw(samp[7]), .rise(hs_edge)
    );
    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk(clk), .reset(reset), .sync_raw(samp[3]), .rise(vs_edge)
    );

    assign rgb_out = {samp[0], samp[4], samp[1], samp[5], samp[2], samp[6]};

    // Position of the pixel currently in the sample stage.
    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (hs_edge) begin
            x_nxt = H_SYNC_START;
        end else if (x_q == H_TOTAL - 10'd1) begin
            x_nxt = 10'd0;
            y_nxt = (y_q == V_TOTAL - 10'd1) ? 10'd0 : y_q + 10'd1;
        end else begin
            x_nxt = x_q + 10'd1;
        end
        if (vs_edge) y_nxt = V_SYNC_START;
    end

    assign tracking  = (state != SEARCH);
    assign rx_x      = tracking ? x_nxt : 10'd0;
    assign rx_y      = tracking ? y_nxt : 10'd0;
    assign rx_active = tracking && (x_nxt < H_ACTIVE) && (y_nxt < V_ACTIVE);

    // hs_edge is folded into the line count before the frame-length check.
    assign v_lines    = (hs_edge && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt;
    assign line_err   = hs_edge && !first_hs && (hcnt + 10'd1 != H_TOTAL);
    assign tmo_err    = (hcnt == H_TIMEOUT);
    assign vframe_err = vs_edge && (v_lines != V_TOTAL);
    assign err        = tracking && (line_err || tmo_err || vframe_err);
    assign frame_good = vs_edge && !frame_bad && !err;

    always_comb begin
        state_nxt = state;
        unique case (state)
            SEARCH:  if (vs_edge) state_nxt = TRACK;
            TRACK: begin
                if (err)
                    state_nxt = SEARCH;
                else if (frame_good && (good_cnt + 8'd1 >= LOCK_N))
                    state_nxt = LOCKED;
            end
            LOCKED:  if (err) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            hcnt       <= 10'd0;
            vcnt       <= 10'd0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            first_hs   <= 1'b1;
            frame_bad  <= 1'b0;
            good_cnt   <= 8'd0;
            run_sum    <= 16'd0;
            frame_sum  <= 16'd0;
            frame_done <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            state     <= state_nxt;
            locked    <= (state_nxt == LOCKED);
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            hcnt      <= hs_edge ? 10'd0 : (tmo_err ? hcnt : hcnt + 10'd1);
            vcnt      <= vs_edge ? 10'd0 : v_lines;
            frame_bad <= vs_edge ? 1'b0 : (frame_bad | err);

            if (state == SEARCH) first_hs <= 1'b1;
            else if (hs_edge)    first_hs <= 1'b0;

            if (state != TRACK)  good_cnt <= 8'd0;
            else if (frame_good) good_cnt <= good_cnt + 8'd1;

            if (vs_edge) begin
                frame_sum <= run_sum;
                run_sum   <= 16'd0;
            end else if (rx_active) begin
                run_sum   <= run_sum + {10'd0, rgb_out};
            end

            frame_done <= locked && frame_good;

            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench: drives 640x480 frames with injected timing faults and
// compares monitor outputs against hand-computed values.
module tb_vga_rx_monitor;

    logic        clk;
    logic        reset;
    logic [7:0]  vga_in;
    logic [9:0]  rx_x, rx_y;
    logic        rx_active;
    logic [5:0]  rgb_out;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frames   = 0;
    int fd_cnt   = 0;
    int rise_frame = -1;
    int fall_cyc   = -1;
    int mark_cyc   = 0;
    logic prev_locked = 1'b0;

    vga_rx_monitor #(.SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .vga_in(vga_in),
        .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .rgb_out(rgb_out),
        .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel: observe outputs at the falling edge, then drive the pin bus.
    // Syncs are active low; colour is constant B1 = rgb 6'b000010.
    task automatic px(input bit hs, input bit vs);
        @(negedge clk);
        cyc++;
        if (frame_done) begin
            fd_cnt++;
            chk("frame_sum", 32'(frame_sum), 32'h6000);
        end
        if (locked && !prev_locked) rise_frame = frames;
        if (!locked && prev_locked) fall_cyc = cyc;
        prev_locked = locked;
        vga_in = {~hs, 3'b000, ~vs, 3'b100};
    endtask

    task automatic line(input int len, input int hsw, input bit vs);
        for (int i = 0; i < len; i++) px(i < hsw, vs);
    endtask

    // Frame starts on the line where vsync asserts (y = 490, x = 656).
    task automatic frame(input int nlines, input int short_at, input int gap_at);
        frames++;
        for (int l = 0; l < nlines; l++) begin
            if (l == short_at + 1 || l == gap_at - 1) mark_cyc = cyc + 1;
            if (l == gap_at) line(1100, 0, 1'b0);
            else             line((l == short_at) ? 799 : 800, 96, l < 2);
        end
    endtask

    task automatic bad_line();
        for (int i = 0; i < 800; i++)
            px(i < 96, (i >= 100 && i < 102) || (i >= 300 && i < 302));
    endtask

    initial begin
        reset  = 1'b1;
        vga_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_sum", 32'(frame_sum), 0);
        chk("rst_rgb", 32'(rgb_out), 0);
        reset = 1'b0;

        line(800, 96, 1'b0);
        line(800, 96, 1'b0);
        chk("search_x", 32'(rx_x), 0);
        chk("search_active", 32'(rx_active), 0);
        chk("search_locked", 32'(locked), 0);

        // Clean stream: lock on the third vs_edge, one frame_done by end of F4.
        repeat (4) frame(525, 9999, 9999);
        chk("lock_frame", rise_frame, 3);
        chk("fd_cnt_clean", fd_cnt, 1);
        chk("err_clean", 32'(err_count), 0);
        chk("pos_x_end", 32'(rx_x), 654);
        chk("pos_y_end", 32'(rx_y), 490);

        // Short line while locked.
        frame(525, 100, 9999);
        chk("short_fall", fall_cyc, mark_cyc + 2);
        chk("short_err", 32'(err_count), 1);
        chk("fd_cnt_short", fd_cnt, 2);
        frame(525, 9999, 9999);
        frame(525, 9999, 9999);

        // Relocked on F8; hsync stalls there until the 1023 timeout.
        frame(525, 9999, 10);
        chk("relock_short", rise_frame, 8);
        chk("tmo_fall", fall_cyc, mark_cyc + 1026);
        chk("tmo_err", 32'(err_count), 2);

        frame(525, 9999, 9999);
        frame(525, 9999, 9999);
        frame(524, 9999, 9999);
        chk("relock_tmo", rise_frame, 11);
        mark_cyc = cyc + 1;
        frame(525, 9999, 9999);
        chk("v524_fall", fall_cyc, mark_cyc + 2);
        chk("v524_err", 32'(err_count), 3);
        chk("v524_no_fd", fd_cnt, 2);

        frame(525, 9999, 9999);
        frame(525, 9999, 9999);
        frame(40, 9999, 9999);
        for (int i = 0; i < 200; i++) px(i < 96, 1'b0);
        chk("relock_v524", rise_frame, 15);
        chk("mid_locked", 32'(locked), 1);
        chk("mid_x", 32'(rx_x), 54);
        chk("mid_y", 32'(rx_y), 6);
        chk("mid_active", 32'(rx_active), 1);
        chk("mid_rgb", 32'(rgb_out), 32'h02);
        chk("mid_sum", 32'(frame_sum), 32'h6000);

        // Asynchronous reset between clock edges.
        #1 reset = 1'b1;
        #1;
        chk("arst_x", 32'(rx_x), 0);
        chk("arst_y", 32'(rx_y), 0);
        chk("arst_active", 32'(rx_active), 0);
        chk("arst_rgb", 32'(rgb_out), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_fd", 32'(frame_done), 0);
        chk("arst_sum", 32'(frame_sum), 0);
        chk("arst_err", 32'(err_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Each bad line carries two vsync pulses: one re-enters TRACK,
        // the second ends a zero-line frame.
        repeat (10) bad_line();
        chk("bad_err_10", 32'(err_count), 10);
        repeat (290) bad_line();
        chk("bad_err_sat", 32'(err_count), 255);
        chk("bad_locked", 32'(locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
